// File: rtl/regfile_2r1w.sv
// regfile_2r1w: two combinational read ports, one synchronous write port.
// After every reset a clear-sweep state machine zeroes each entry in turn,
// one entry per clock, and only then raises READY and accepts writes.
// Entry 0 can be hardwired to zero (ZERO_REG=1, RISC-V x0 style).
// Optional build macro: REGFILE_BYPASS_EN. When it is defined, a write
// accepted this cycle is forwarded to a read port addressing the same entry.
module regfile_2r1w #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic [AW-1:0]    WADDR,
  input  logic [WIDTH-1:0] WDATA,
  input  logic [AW-1:0]    RADDR1,
  output logic [WIDTH-1:0] RDATA1,
  input  logic [AW-1:0]    RADDR2,
  output logic [WIDTH-1:0] RDATA2,
  output logic             READY
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [AW-1:0]      ptr_r;
  logic [AW-1:0]      ptr_nxt_s;
  logic               ready_r;
  logic               ready_nxt_s;
  logic [WIDTH-1:0]   mem_r [DEPTH];

  logic               mem_we_s;
  logic [AW-1:0]      mem_waddr_s;
  logic [WIDTH-1:0]   mem_wdata_s;

  logic               run_s;
  logic [WIDTH-1:0]   rdata1_s;
  logic [WIDTH-1:0]   rdata2_s;

  // True when the address names the hardwired-zero entry.
  function automatic logic is_zero_addr(input logic [AW-1:0] addr);
    return (ZERO_REG != 0) && (addr == {AW{1'b0}});
  endfunction

  // Value presented from storage: zero during the sweep or for the zero entry.
  function automatic logic [WIDTH-1:0] stored_read(
    input logic [AW-1:0]    raddr,
    input logic [WIDTH-1:0] stored,
    input logic             run
  );
    if (!run || is_zero_addr(raddr)) begin
      return {WIDTH{1'b0}};
    end else begin
      return stored;
    end
  endfunction

  assign run_s = (state_r == ST_RUN);

  // Sweep/run control registers; reset restarts the sweep from entry 0.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_INIT;
      ptr_r   <= {AW{1'b0}};
      ready_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ptr_r   <= ptr_nxt_s;
      ready_r <= ready_nxt_s;
    end
  end

  // Next-state logic and selection of the single array write per cycle.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    ready_nxt_s = ready_r;
    mem_we_s    = 1'b0;
    mem_waddr_s = ptr_r;
    mem_wdata_s = {WIDTH{1'b0}};
    case (state_r)
      ST_INIT: begin
        // Clear one entry per clock; user writes are ignored here.
        mem_we_s    = 1'b1;
        mem_waddr_s = ptr_r;
        mem_wdata_s = {WIDTH{1'b0}};
        ptr_nxt_s   = ptr_r + AW'(1'b1);
        if (ptr_r == AW'(DEPTH - 1)) begin
          state_nxt_s = ST_RUN;
          ready_nxt_s = 1'b1;
        end else begin
          state_nxt_s = ST_INIT;
          ready_nxt_s = 1'b0;
        end
      end
      ST_RUN: begin
        if (WE && !is_zero_addr(WADDR)) begin
          mem_we_s    = 1'b1;
          mem_waddr_s = WADDR;
          mem_wdata_s = WDATA;
        end else begin
          mem_we_s    = 1'b0;
        end
      end
      default: begin
        state_nxt_s = ST_INIT;
        ptr_nxt_s   = {AW{1'b0}};
        ready_nxt_s = 1'b0;
      end
    endcase
  end

  // Storage array; nothing is written on a reset edge.
  always_ff @(posedge CLK) begin
    if (!RST && mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd1_s;
  logic fwd2_s;

  assign fwd1_s = run_s && WE && (RADDR1 == WADDR) && !is_zero_addr(WADDR);
  assign fwd2_s = run_s && WE && (RADDR2 == WADDR) && !is_zero_addr(WADDR);

  // Read ports with same-cycle write forwarding.
  always_comb begin
    rdata1_s = fwd1_s ? WDATA : stored_read(RADDR1, mem_r[RADDR1], run_s);
    rdata2_s = fwd2_s ? WDATA : stored_read(RADDR2, mem_r[RADDR2], run_s);
  end
`else
  // Read ports reflecting stored contents only.
  always_comb begin
    rdata1_s = stored_read(RADDR1, mem_r[RADDR1], run_s);
    rdata2_s = stored_read(RADDR2, mem_r[RADDR2], run_s);
  end
`endif

  assign RDATA1 = rdata1_s;
  assign RDATA2 = rdata2_s;
  assign READY  = ready_r;

endmodule

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised two-read/one-write register file for the RV523 datapath, replacing hand-instantiated banks of `D_LATCH` cells with one generic block. It is generalised in word width, depth and the hardwired-zero entry. It adds a hardware clear-sweep state machine that zeroes every entry after reset and raises `READY` when done. It sits between decode (read addresses) and writeback (write port).

## Interface

**Parameters**
- `WIDTH`, 32: bits per entry.
- `DEPTH`, 32: number of entries. Must be a power of two, ≥2.
- `ZERO_REG`, 1: when 1, entry 0 is hardwired to zero (RISC-V x0).
- `AW` (derived, not overridable): `$clog2(DEPTH)`.

**Ports**
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: reset, synchronous, active-high.
- `WE` in 1: write enable.
- `WADDR` in AW: write address.
- `WDATA` in WIDTH: write data.
- `RADDR1` in AW: read port 1 address.
- `RDATA1` out WIDTH: read port 1 data, combinational.
- `RADDR2` in AW: read port 2 address.
- `RDATA2` out WIDTH: read port 2 data, combinational.
- `READY` out 1: high once the clear sweep is complete and writes are accepted.

## Operation

**States**
- Two states: `INIT` (clear sweep) and `RUN`.
- Sweep pointer `ptr` is AW bits wide.

**Reset**
- Any rising edge with `RST`=1 sets state `INIT`, `ptr`=0 and `READY`=0.
- No entry is written on that edge.
- Reset values: `READY`=0, `RDATA1`=`RDATA2`=0.

**INIT**
- On each edge with `RST`=0: `entry[ptr]` ← 0 and `ptr` ← `ptr`+1.
- The edge that clears `entry[DEPTH-1]` moves the state to `RUN` and sets `READY`=1.
- `ptr` wraps to 0 at that edge.

**RUN**
- On an edge with `WE`=1: `entry[WADDR]` ← `WDATA`.
- The write is suppressed when `ZERO_REG`=1 and `WADDR`=0.

**Writes while not ready**
- `WE` in `INIT`, or on an edge where `RST`=1, is dropped silently.
- It is not queued and not replayed.

**Reads**
- `RDATAn` = `entry[RADDRn]` in `RUN`.
- `RDATAn` is forced to 0 when `ZERO_REG`=1 and `RADDRn`=0.
- `RDATAn` is forced to 0 whenever state is `INIT`, regardless of array contents.
- Both ports are independent. Identical addresses on both ports are legal and return identical data.

**Reset mid-operation**
- `RST` asserted in `RUN` returns the block to `INIT`.
- A full sweep runs again and all prior contents are lost.
- `RST` asserted during `INIT` restarts the sweep from `ptr`=0.

**Width rules**
- Every AW-bit address is valid; there is no out-of-range case.
- `WDATA` is stored unmodified.

## Timing

- Write latency: data written at edge *n* is visible on `RDATA` after edge *n*, i.e. in cycle *n*+1.
- Read latency: 0 cycles (combinational from `RADDR`).
- `READY` latency: `READY` rises at exactly the DEPTH-th rising edge with `RST`=0 following the last reset edge.
- `READY` falls at the first edge with `RST`=1.
- Same-cycle write and read to the same address: `RDATA` shows the old value, unless `REGFILE_BYPASS_EN` is defined (see Configuration).

## Configuration

- Macro: `REGFILE_BYPASS_EN`.
- **Defined:** write-to-read forwarding is compiled in. `RDATAn` = `WDATA` combinationally when all of the following hold:
  - state is `RUN`
  - `WE`=1
  - `RADDRn`=`WADDR`
  - the target is not the hardwired-zero entry
- **Undefined:** no forwarding. `RDATAn` always reflects stored contents.
- Edge behaviour is identical in both builds.

## Test plan

All scenarios use `WIDTH`=32, `DEPTH`=32, `ZERO_REG`=1.

- **Reset sweep:** `RST`=1 for 2 cycles, then released → `READY`=0 for 31 edges and 1 after the 32nd. Afterwards all 32 addresses read 0 on both ports.
- **Basic write/read:** write 0xDEADBEEF to addr 5, then `RADDR1`=`RADDR2`=5 next cycle → both read 0xDEADBEEF. Addr 6 still reads 0.
- **Hardwired zero:** write 0x12345678 to addr 0 → `RDATA1` for addr 0 reads 0x00000000.
- **Write during sweep:** `WE`=1, addr 3, 0xFFFFFFFF on the 10th post-reset edge → dropped; after `READY`, addr 3 reads 0.
- **Same-cycle write/read:** write 0xA5A5A5A5 to addr 7 with `RADDR1`=7 in the same cycle (addr 7 previously 0):
  - with `REGFILE_BYPASS_EN`, `RDATA1`=0xA5A5A5A5 that cycle;
  - without it, `RDATA1`=0 that cycle and 0xA5A5A5A5 the next.
- **Mid-operation reset:** write 0x00000001 to addr 31, then pulse `RST` for 1 cycle → `READY`=0 after that edge; 32 edges later `READY`=1 and addr 31 reads 0.
